// File: rtl/ff_pkg.sv
// Shared constants, FSM state type and helpers for the pseudo-Mersenne reducer.
package ff_pkg;

    localparam int unsigned  SECP256K1_W   = 256;
    localparam int unsigned  SECP256K1_C_W = 33;
    localparam logic [63:0]  SECP256K1_C   = 64'h0000_0001_0000_03D1;
    localparam logic [255:0] SECP256K1_P   = 256'(0) - 256'(SECP256K1_C);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Number of DIGIT-wide slices needed to cover a c_w-bit fold constant.
    function automatic int unsigned nd_calc(input int unsigned c_w, input int unsigned digit);
        return (c_w + digit - 1) / digit;
    endfunction

endpackage

// File: rtl/ff_reduce_pm_if.sv
// Product-in / residue-out handshake bundle for ff_reduce_pm.
interface ff_reduce_pm_if #(
    parameter int unsigned W = ff_pkg::SECP256K1_W
);
    logic           rx_valid;
    logic           rx_ready;
    logic [2*W-1:0] rx_a;
    logic           tx_valid;
    logic           tx_ready;
    logic [W-1:0]   tx_a;
    logic [1:0]     tx_passes;

    modport master (
        output rx_valid, rx_a, tx_ready,
        input  rx_ready, tx_valid, tx_a, tx_passes
    );

    modport slave (
        input  rx_valid, rx_a, tx_ready,
        output rx_ready, tx_valid, tx_a, tx_passes
    );
endinterface

// File: rtl/ff_mac_digit.sv
// One digit step of the fold: acc + (h * c_digit) << (idx * DIGIT), purely combinational.
module ff_mac_digit #(
    parameter  int unsigned W     = 256,
    parameter  int unsigned C_W   = 33,
    parameter  int unsigned DIGIT = 11,
    parameter  int unsigned IW    = 2,
    localparam int unsigned AW    = W + C_W + 1
) (
    input  logic [AW-1:0]    acc,
    input  logic [W-1:0]     h,
    input  logic [DIGIT-1:0] c_digit,
    input  logic [IW-1:0]    idx,
    output logic [AW-1:0]    acc_sum_c
);
    localparam int unsigned PW = W + DIGIT;

    logic [PW-1:0] prod;

    assign prod      = PW'(h) * PW'(c_digit);
    assign acc_sum_c = acc + (AW'(prod) << (32'(idx) * DIGIT));

endmodule

// File: rtl/ff_reduce_pm.sv
// Digit-serial pseudo-Mersenne reducer: x (2W bits) -> x mod (2^W - C), fully reduced.
module ff_reduce_pm
    import ff_pkg::*;
#(
    parameter int unsigned W     = SECP256K1_W,
    parameter int unsigned C_W   = SECP256K1_C_W,
    parameter logic [63:0] C     = SECP256K1_C,
    parameter int unsigned DIGIT = 11
) (
    input logic          clk,
    input logic          reset_n,
    ff_reduce_pm_if.slave bus
);
    localparam int unsigned ND   = nd_calc(C_W, DIGIT);
    localparam int unsigned IW   = (ND > 1) ? $clog2(ND) : 1;
    localparam int unsigned AW   = W + C_W + 1;
    localparam int unsigned CXW  = ND * DIGIT;
    localparam logic [W-1:0]   P     = W'(0) - W'(C);
    localparam logic [CXW-1:0] C_EXT = CXW'(C);

    // Parameter sanity: the 3-pass bound relies on 2*C_W+2 < W.
    if ((2 * C_W + 2) >= W) begin : g_bad_cw
        $error("ff_reduce_pm: C_W too large for W (need 2*C_W+2 < W)");
    end
    if ((C >> C_W) != 64'd0) begin : g_bad_c
        $error("ff_reduce_pm: C does not fit in C_W bits");
    end

    state_t         state_q, state_d;
    logic [W-1:0]   h_q, h_d;
    logic [W-1:0]   l_q, l_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [IW-1:0]  digit_q, digit_d;
    logic [1:0]     passes_q, passes_d;
    logic           rx_ready_q, rx_ready_d;
    logic           tx_valid_q, tx_valid_d;
    logic [W-1:0]   tx_a_q, tx_a_d;
    logic [1:0]     tx_passes_q, tx_passes_d;

    logic [DIGIT-1:0] c_digit;
    logic [AW-1:0]    mac_sum;
    logic             hi_nz;
    logic             last_digit;
    logic [W:0]       diff;

    assign c_digit    = C_EXT[32'(digit_q) * DIGIT +: DIGIT];
    assign hi_nz      = (mac_sum[AW-1:W] != '0);
    assign last_digit = (digit_q == IW'(ND - 1));
    // Borrow out of the (W+1)-bit subtraction means s < p and s is kept.
    assign diff       = {1'b0, l_q} - {1'b0, P};

    ff_mac_digit #(
        .W     (W),
        .C_W   (C_W),
        .DIGIT (DIGIT),
        .IW    (IW)
    ) u_mac (
        .acc       (acc_q),
        .h         (h_q),
        .c_digit   (c_digit),
        .idx       (digit_q),
        .acc_sum_c (mac_sum)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            h_q         <= '0;
            l_q         <= '0;
            acc_q       <= '0;
            digit_q     <= '0;
            passes_q    <= '0;
            rx_ready_q  <= 1'b1;
            tx_valid_q  <= 1'b0;
            tx_a_q      <= '0;
            tx_passes_q <= '0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            l_q         <= l_d;
            acc_q       <= acc_d;
            digit_q     <= digit_d;
            passes_q    <= passes_d;
            rx_ready_q  <= rx_ready_d;
            tx_valid_q  <= tx_valid_d;
            tx_a_q      <= tx_a_d;
            tx_passes_q <= tx_passes_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        l_d         = l_q;
        acc_d       = acc_q;
        digit_d     = digit_q;
        passes_d    = passes_q;
        tx_valid_d  = tx_valid_q;
        tx_a_d      = tx_a_q;
        tx_passes_d = tx_passes_q;

        unique case (state_q)
            IDLE: begin
                if (bus.rx_valid && rx_ready_q) begin
                    l_d      = bus.rx_a[W-1:0];
                    h_d      = bus.rx_a[2*W-1:W];
                    acc_d    = AW'(bus.rx_a[W-1:0]);
                    digit_d  = '0;
                    passes_d = '0;
                    state_d  = (bus.rx_a[2*W-1:W] != '0) ? FOLD : SUB;
                end
            end
            FOLD: begin
                acc_d   = mac_sum;
                digit_d = digit_q + IW'(1);
                // End of pass: split acc into new low/high halves and restart if high is nonzero.
                if (last_digit) begin
                    digit_d  = '0;
                    l_d      = mac_sum[W-1:0];
                    h_d      = W'(mac_sum[AW-1:W]);
                    acc_d    = AW'(mac_sum[W-1:0]);
                    passes_d = passes_q + 2'd1;
                    state_d  = hi_nz ? FOLD : SUB;
                end
            end
            SUB: begin
                tx_a_d      = diff[W] ? l_q : diff[W-1:0];
                tx_passes_d = passes_q;
                tx_valid_d  = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
        endcase

        rx_ready_d = (state_d == IDLE);
    end

    // The fold must converge within three passes for any legal parameter set.
    always_ff @(posedge clk) begin
        if (reset_n && state_q == FOLD && last_digit) begin
            assert (!(hi_nz && passes_q == 2'd2))
            else $fatal(1, "ff_reduce_pm: fold needed a fourth pass");
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_a      = tx_a_q;
    assign bus.tx_passes = tx_passes_q;

endmodule

// File: tb/tb_ff_reduce_pm.sv
// Randomized self-checking bench for ff_reduce_pm against a long-division reference.
module tb_ff_reduce_pm;
    import ff_pkg::*;

    localparam int unsigned W   = SECP256K1_W;
    localparam logic [W-1:0] P  = SECP256K1_P;
    localparam logic [63:0] CF  = SECP256K1_C;
    localparam int unsigned ND  = 3;
    localparam int NRAND        = 1500;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    ff_reduce_pm_if #(.W(W)) bus ();

    ff_reduce_pm #(
        .W     (W),
        .C_W   (SECP256K1_C_W),
        .C     (CF),
        .DIGIT (11)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference residue by plain binary long division.
    function automatic logic [W-1:0] ref_mod(input logic [511:0] x);
        logic [W:0] r;
        r = '0;
        for (int i = 511; i >= 0; i--) begin
            r = {r[W-1:0], x[i]};
            if (r >= {1'b0, P}) r = r - {1'b0, P};
        end
        return r[W-1:0];
    endfunction

    // Number of whole folds x = lo + hi*C needed until the high half vanishes.
    function automatic int ref_passes(input logic [511:0] x);
        logic [600:0] v;
        int n;
        v = 601'(x);
        n = 0;
        while ((v >> W) != '0 && n < 8) begin
            v = 601'(v[W-1:0]) + (v >> W) * 601'(CF);
            n++;
        end
        return n;
    endfunction

    task automatic run_txn(input logic [511:0] x, input string tag, input int hold);
        logic [W-1:0] exp_a;
        int exp_p;
        int lat;
        int guard;
        exp_a = ref_mod(x);
        exp_p = ref_passes(x);
        guard = 0;
        while (!bus.rx_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_rdy"}, 512'(bus.rx_ready), 512'(1));
        bus.rx_a     = x;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        bus.rx_a     = ~x;
        check({tag, "_busy"}, 512'(bus.rx_ready), 512'(0));
        lat = 0;
        while (!bus.tx_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_valid"}, 512'(bus.tx_valid), 512'(1));
        check({tag, "_a"}, 512'(bus.tx_a), 512'(exp_a));
        check({tag, "_passes"}, 512'(bus.tx_passes), 512'(exp_p));
        check({tag, "_lat"}, 512'(lat), 512'(exp_p * ND + 1));
        check({tag, "_ltp"}, 512'(bus.tx_a < P), 512'(1));
        for (int i = 0; i < hold; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_a     = {$urandom(), 480'(0)};
            @(posedge clk); #1;
            check({tag, "_hold_a"}, 512'(bus.tx_a), 512'(exp_a));
            check({tag, "_hold_rdy"}, 512'({bus.rx_ready, bus.tx_valid}), 512'(2'b01));
        end
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        @(posedge clk); #1;
        bus.tx_ready = 1'b0;
        check({tag, "_drop"}, 512'({bus.rx_ready, bus.tx_valid}), 512'(2'b10));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] x;
        logic [511:0] pm1;
        logic [511:0] sq;
        int kind;

        reset_n      = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_a     = '0;
        bus.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", 512'(bus.rx_ready), 512'(1));
        check("rst_valid", 512'(bus.tx_valid), 512'(0));
        check("rst_a", 512'(bus.tx_a), 512'(0));
        check("rst_passes", 512'(bus.tx_passes), 512'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        pm1 = 512'(P) - 512'(1);
        sq  = pm1 * pm1;

        run_txn(512'(0), "zero", 0);
        run_txn(512'(P), "p", 0);
        x = 512'({W{1'b1}});
        run_txn(x, "lo_max", 0);
        check("lo_max_const", 512'(bus.tx_a), 512'(64'h1_0000_03D0));
        run_txn(sq, "pm1_sq", 20);
        check("pm1_sq_one", 512'(bus.tx_a), 512'(1));
        run_txn({512{1'b1}}, "all_ones", 0);

        // Abort in the middle of the second fold pass.
        bus.rx_a     = sq;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_rdy", 512'(bus.rx_ready), 512'(1));
        check("abort_valid", 512'(bus.tx_valid), 512'(0));
        check("abort_a", 512'(bus.tx_a), 512'(0));
        check("abort_passes", 512'(bus.tx_passes), 512'(0));
        repeat (2) begin
            @(posedge clk); #1;
            check("abort_hold", 512'(bus.tx_valid), 512'(0));
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_txn(sq, "post_abort", 0);

        for (int n = 0; n < NRAND; n++) begin
            for (int k = 0; k < 16; k++) x[k*32 +: 32] = $urandom();
            kind = int'($urandom_range(0, 3));
            case (kind)
                1: x[511:300] = '0;
                2: begin x[511:W] = '0; x[W-1:40] = '1; end
                3: begin x[511:W] = 256'(1); x[W-1:40] = '1; end
                default: ;
            endcase
            run_txn(x, "rand", 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
